data_sram_responder: RTL and testbench
======================================

Name: data_sram_responder

Overview:
- Responder end of the data-SRAM interface that the pipeline memory stage drives with en / we / addr / wdata, and from which it samples rdata.
- Models the word-organised data RAM behind that interface: byte-lane writes, registered reads, and programmable wait states.
- During wait states it raises a stall that feeds the memory stage's stall input.
- Used as the data memory in core-level simulation and as a drop-in FPGA BRAM wrapper.

Parameters:
- ADDR_W, 14: word-address width; capacity is 2^ADDR_W 32-bit words.
- WAIT_CYCLES, 0: extra busy cycles per accepted request, 0..15.
- RESET_RDATA, 32'h0: rdata value after reset.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- data_sram_en  in  1  request strobe.
- data_sram_we  in  4  byte write enables; bit i writes wdata[8i+7:8i].
- data_sram_addr  in  32  byte address.
- data_sram_wdata  in  32  write data, already lane-aligned by the requester.
- data_sram_rdata  out  32  read data, registered.
- data_sram_stall  out  1  responder busy; requests are ignored while high.
- resp_valid  out  1  one-cycle pulse when rdata holds a new response.
- addr_err  out  1  sticky out-of-range flag; see Optional Feature.

Behaviour:
- Reset values:
  - state=IDLE, data_sram_rdata=RESET_RDATA, data_sram_stall=0, resp_valid=0, addr_err=0, wait counter=0.
  - Memory array is not cleared by reset.
- Word index = addr[ADDR_W+1:2]. addr[1:0] is ignored; byte extraction and sign extension are the requester's job.
- Accept: a request is accepted on an edge where en=1 and state is IDLE, or RESP with WAIT_CYCLES=0.
- Write commit:
  - Byte lanes with we[i]=1 are written at the accepting edge.
  - we=0 with en=1 is a pure read.
- Read data:
  - Every accepted request loads rdata with the word after the write merge (write-first).
  - A partial store therefore returns the merged word.
- Latency:
  - WAIT_CYCLES=0: request in cycle N gives rdata and resp_valid=1 in cycle N+1. Back-to-back requests every cycle are supported; stall stays 0.
  - WAIT_CYCLES=k>0: the accepting edge enters WAIT and loads counter=k; stall=1 from cycle N+1 through N+k. Cycle N+k+1 enters RESP, with rdata valid, resp_valid=1 and stall=0.
  - In WAIT, rdata holds its previous value until RESP.
- FSM:
  - IDLE -> (accept, k=0) RESP; IDLE -> (accept, k>0) WAIT.
  - WAIT: counter decrements each cycle; counter reaching 1 -> RESP.
  - RESP -> (accept, k=0) RESP; RESP -> (accept, k>0) WAIT; RESP -> (no en) IDLE.
  - With k>0, requests seen in RESP are not accepted; the FSM goes to IDLE first. Minimum spacing between accepts is k+2 cycles.
- Hold: en/we/addr/wdata are ignored while stall=1. A requester holding en high is serviced again once IDLE is reached.
- rdata holds its last value when no request is accepted. resp_valid is 1 only in the single RESP cycle.
- Reset mid-WAIT: the pending response is dropped and no resp_valid follows. The write was already committed at accept.
- Reset has priority over an accept in the same cycle; no write occurs on a reset edge.

Optional Feature:
- Macro: DATA_SRAM_RANGE_CHECK_EN.
- Defined:
  - An accepted request with any addr[31:ADDR_W+2] nonzero sets addr_err=1 (sticky until reset).
  - Its write is suppressed, rdata returns 32'hDEADBEEF, and timing is unchanged.
- Undefined: upper address bits are ignored (addresses alias modulo 2^(ADDR_W+2)) and addr_err is tied to 0.

Test Plan:
- WAIT_CYCLES=0: write addr 0x10, we=4'hF, wdata 0x12345678; next cycle read 0x10 -> rdata=0x12345678, resp_valid=1 one cycle after each request, stall never 1.
- Byte merge: word 0x20 holds 0xAABBCCDD; write we=4'b0100, wdata 0x00EE0000 -> response rdata=0xAAEECCDD; a subsequent read of 0x23 returns the same word.
- WAIT_CYCLES=3: read accepted in cycle N -> stall=1 in N+1..N+3, rdata/resp_valid in N+4; a changed addr presented during stall is not serviced.
- Reset at N+2 of a WAIT_CYCLES=3 write to 0x40 of 0x55AA55AA -> no resp_valid, outputs at reset values; later read 0x40 returns 0x55AA55AA.
- Back-to-back reads of 0x0, 0x4, 0x8 with k=0 -> rdata sequence in three consecutive cycles, resp_valid held 1 for three cycles.
- DATA_SRAM_RANGE_CHECK_EN, ADDR_W=14: write to 0x00010000 -> addr_err=1, rdata=0xDEADBEEF, word 0 unchanged. Without the macro the same write lands in word 0.

Source files
------------

// File: rtl/data_sram_responder.sv
// data_sram_responder
//   Responder side of the data-SRAM interface. Holds a word-organised RAM of
//   2^ADDR_W 32-bit words. It supports byte-lane writes and write-first
//   registered reads, and it can insert WAIT_CYCLES busy cycles per request.
//   During those busy cycles it raises data_sram_stall.
//
// Ports
//   clk               system clock, rising edge
//   reset             synchronous, active-high
//   data_sram_en      request strobe
//   data_sram_we[3:0] byte write enables (bit i -> wdata[8i+7:8i])
//   data_sram_addr    byte address; word index = addr[ADDR_W+1:2]
//   data_sram_wdata   lane-aligned write data
//   data_sram_rdata   registered read data (merged word for stores)
//   data_sram_stall   busy; requests are ignored while high
//   resp_valid        one-cycle pulse when rdata carries a new response
//   addr_err          sticky out-of-range flag
//
// Optional feature: define DATA_SRAM_RANGE_CHECK_EN to flag accesses with
// nonzero address bits above the RAM. Such an access sets addr_err, its
// write is suppressed and it returns 32'hDEADBEEF. Without the macro, upper
// address bits alias and addr_err is held at 0.
module data_sram_responder #(
  parameter int unsigned ADDR_W      = 14,
  parameter int unsigned WAIT_CYCLES = 0,
  parameter logic [31:0] RESET_RDATA = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_we,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic        data_sram_stall,
  output logic        resp_valid,
  output logic        addr_err
);

  localparam int unsigned DEPTH     = 1 << ADDR_W;
  localparam logic [3:0]  K         = 4'(WAIT_CYCLES);
  localparam bit          ZERO_WAIT = (WAIT_CYCLES == 0);
  localparam logic [31:0] ERR_WORD  = 32'hDEADBEEF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] pend_q, pend_d;   // response parked until the WAIT phase ends
  logic        err_q, err_d;

  logic [31:0] mem [DEPTH];

  logic              accept;
  logic [ADDR_W-1:0] word_idx;
  logic [31:0]       lane_mask;
  logic [31:0]       merged;
  logic [31:0]       resp_word;
  logic              range_bad;
  logic              do_write;

`ifdef DATA_SRAM_RANGE_CHECK_EN
  assign range_bad = |data_sram_addr[31:ADDR_W+2];
  logic unused_addr_bits;
  assign unused_addr_bits = ^data_sram_addr[1:0];
`else
  assign range_bad = 1'b0;
  logic unused_addr_bits;
  assign unused_addr_bits = ^{data_sram_addr[1:0], data_sram_addr[31:ADDR_W+2]};
`endif

  // With wait states, a request arriving in RESP is not taken. The FSM
  // drops to IDLE first, so consecutive accepts are at least k+2 cycles apart.
  assign accept   = data_sram_en &&
                    ((state_q == ST_IDLE) || ((state_q == ST_RESP) && ZERO_WAIT));
  assign word_idx = data_sram_addr[ADDR_W+1:2];

  always_comb begin
    lane_mask = '0;
    for (int i = 0; i < 4; i++) lane_mask[8*i +: 8] = {8{data_sram_we[i]}};
  end

  // Write-first: the response is the stored word after the byte merge.
  assign merged    = (mem[word_idx] & ~lane_mask) | (data_sram_wdata & lane_mask);
  assign resp_word = range_bad ? ERR_WORD : merged;
  assign do_write  = accept && (|data_sram_we) && !range_bad;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    pend_d  = pend_q;
    err_d   = err_q | (accept & range_bad);
    unique case (state_q)
      ST_IDLE, ST_RESP: begin
        if (accept) begin
          if (ZERO_WAIT) begin
            state_d = ST_RESP;
            rdata_d = resp_word;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = K;
            pend_d  = resp_word;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_q <= 4'd1) begin
          state_d = ST_RESP;
          cnt_d   = '0;
          rdata_d = pend_q;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rdata_q <= RESET_RDATA;
      pend_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      pend_q  <= pend_d;
      err_q   <= err_d;
    end
  end

  // The RAM contents survive reset. A write is blocked on a reset edge.
  always_ff @(posedge clk) begin
    if (!reset && do_write) mem[word_idx] <= merged;
  end

  assign data_sram_rdata = rdata_q;
  assign data_sram_stall = (state_q == ST_WAIT);
  assign resp_valid      = (state_q == ST_RESP);
  assign addr_err        = err_q;

endmodule

// File: tb/tb_data_sram_responder.sv
module tb_data_sram_responder;
  localparam int AW = 14;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst0, en0, stall0, rv0, err0;
  logic [3:0]  we0;
  logic [31:0] addr0, wdata0, rdata0;
  logic        rst3, en3, stall3, rv3, err3;
  logic [3:0]  we3;
  logic [31:0] addr3, wdata3, rdata3;

  data_sram_responder #(.ADDR_W(AW), .WAIT_CYCLES(0), .RESET_RDATA(32'h0)) dut0 (
    .clk(clk), .reset(rst0), .data_sram_en(en0), .data_sram_we(we0),
    .data_sram_addr(addr0), .data_sram_wdata(wdata0), .data_sram_rdata(rdata0),
    .data_sram_stall(stall0), .resp_valid(rv0), .addr_err(err0));

  data_sram_responder #(.ADDR_W(AW), .WAIT_CYCLES(3), .RESET_RDATA(32'h0)) dut3 (
    .clk(clk), .reset(rst3), .data_sram_en(en3), .data_sram_we(we3),
    .data_sram_addr(addr3), .data_sram_wdata(wdata3), .data_sram_rdata(rdata3),
    .data_sram_stall(stall3), .resp_valid(rv3), .addr_err(err3));

  int checks = 0;
  int errors = 0;
  logic [31:0] m0 [1<<AW];
  logic [31:0] m3 [1<<AW];
  logic [31:0] last0, last3;
  logic        exp_err0;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  function automatic bit oob(input logic [31:0] a);
`ifdef DATA_SRAM_RANGE_CHECK_EN
    return (a >> (AW + 2)) != 0;
`else
    return 1'b0;
`endif
  endfunction

  // Reference behaviour: each byte lane is taken from wdata when enabled.
  task automatic model(input int which, input logic [3:0] we, input logic [31:0] a,
                       input logic [31:0] wd, output logic [31:0] exp);
    int idx;
    logic [31:0] w;
    idx = int'((a / 4) % (1 << AW));
    if (oob(a)) begin
      exp = 32'hDEADBEEF;
      return;
    end
    w = (which == 0) ? m0[idx] : m3[idx];
    for (int b = 0; b < 4; b++)
      if (we[b]) w[8*b +: 8] = wd[8*b +: 8];
    if (which == 0) m0[idx] = w; else m3[idx] = w;
    exp = w;
  endtask

  // Zero-wait request: the response is visible one cycle after the request.
  // en stays high, so consecutive calls are back-to-back requests.
  task automatic op0(input logic [3:0] we, input logic [31:0] a, input logic [31:0] wd);
    logic [31:0] exp;
    model(0, we, a, wd, exp);
    if (oob(a)) exp_err0 = 1'b1;
    en0 = 1'b1; we0 = we; addr0 = a; wdata0 = wd;
    tick();
    chk("k0_rdata", rdata0, exp);
    chk("k0_rv", {31'b0, rv0}, 32'd1);
    chk("k0_stall", {31'b0, stall0}, 32'd0);
    chk("k0_err", {31'b0, err0}, {31'b0, exp_err0});
    last0 = exp;
  endtask

  task automatic idle0();
    en0 = 1'b0; we0 = 4'h0;
    tick();
    chk("k0_idle_rv", {31'b0, rv0}, 32'd0);
    chk("k0_idle_hold", rdata0, last0);
  endtask

  // Three-wait request: three stall cycles, then one response cycle, then IDLE.
  // During the stall, different requests are driven and must be ignored.
  task automatic op3(input logic [3:0] we, input logic [31:0] a, input logic [31:0] wd);
    logic [31:0] exp;
    model(3, we, a, wd, exp);
    en3 = 1'b1; we3 = we; addr3 = a; wdata3 = wd;
    tick();
    en3 = 1'b1; we3 = 4'hF;
    addr3 = 32'($urandom_range(0, 7)) << 2; wdata3 = $urandom;
    for (int j = 1; j <= 3; j++) begin
      chk("k3_stall", {31'b0, stall3}, 32'd1);
      chk("k3_rv_wait", {31'b0, rv3}, 32'd0);
      chk("k3_rdata_hold", rdata3, last3);
      if (j == 3) en3 = 1'b0;
      tick();
    end
    chk("k3_rv", {31'b0, rv3}, 32'd1);
    chk("k3_rdata", rdata3, exp);
    chk("k3_stall_resp", {31'b0, stall3}, 32'd0);
    last3 = exp;
    tick();
    chk("k3_rv_after", {31'b0, rv3}, 32'd0);
    chk("k3_rdata_after", rdata3, exp);
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout");
    $fatal(1);
  end

  initial begin
    logic [31:0] a, wd, w0_before;
    logic [3:0]  we;
    rst0 = 1; en0 = 0; we0 = 0; addr0 = 0; wdata0 = 0;
    rst3 = 1; en3 = 0; we3 = 0; addr3 = 0; wdata3 = 0;
    last0 = 32'h0; last3 = 32'h0; exp_err0 = 1'b0;
    tick(); tick();
    rst0 = 0; rst3 = 0;
    tick();
    chk("rst0_rdata", rdata0, 32'h0);
    chk("rst0_rv", {31'b0, rv0}, 32'd0);
    chk("rst0_stall", {31'b0, stall0}, 32'd0);
    chk("rst0_err", {31'b0, err0}, 32'd0);
    chk("rst3_rdata", rdata3, 32'h0);
    chk("rst3_rv", {31'b0, rv3}, 32'd0);
    chk("rst3_stall", {31'b0, stall3}, 32'd0);
    chk("rst3_err", {31'b0, err3}, 32'd0);

    // ---------------- WAIT_CYCLES = 0 ----------------
    for (int i = 0; i < 16; i++) op0(4'hF, 32'(i * 4), $urandom);
    op0(4'hF, 32'h10, 32'h12345678);
    op0(4'h0, 32'h10, 32'h0);
    op0(4'hF, 32'h20, 32'hAABBCCDD);
    op0(4'b0100, 32'h20, 32'h00EE0000);
    chk("merge_word", last0, 32'hAAEECCDD);
    op0(4'h0, 32'h23, 32'h0);
    chk("merge_reread", rdata0, 32'hAAEECCDD);
    idle0();
    op0(4'h0, 32'h0, 32'h0);
    op0(4'h0, 32'h4, 32'h0);
    op0(4'h0, 32'h8, 32'h0);
    idle0();
    for (int i = 0; i < 40; i++) begin
      we = 4'($urandom);
      a  = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
      op0(we, a, $urandom);
      if ((i % 7) == 6) idle0();
    end
    idle0();
    // Out-of-range write: an error under the range check, otherwise it aliases onto word 0.
    w0_before = m0[0];
    op0(4'hF, 32'h00010000, 32'hCAFEF00D);
`ifdef DATA_SRAM_RANGE_CHECK_EN
    chk("oob_rdata", rdata0, 32'hDEADBEEF);
    chk("oob_err", {31'b0, err0}, 32'd1);
    chk("oob_word0_kept", m0[0], w0_before);
`else
    chk("alias_rdata", rdata0, 32'hCAFEF00D);
    chk("alias_err", {31'b0, err0}, 32'd0);
`endif
    op0(4'h0, 32'h0, 32'h0);
    idle0();

    // ---------------- WAIT_CYCLES = 3 ----------------
    for (int i = 0; i < 8; i++) op3(4'hF, 32'(i * 4), $urandom);
    for (int i = 0; i < 12; i++) begin
      we = 4'($urandom);
      a  = (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
      op3(we, a, $urandom);
    end
    // Reset in the second stall cycle of a write: the write remains, the response is lost.
    model(3, 4'hF, 32'h40, 32'h55AA55AA, wd);
    en3 = 1; we3 = 4'hF; addr3 = 32'h40; wdata3 = 32'h55AA55AA;
    tick();
    en3 = 0; we3 = 0;
    chk("rstw_stall1", {31'b0, stall3}, 32'd1);
    tick();
    chk("rstw_stall2", {31'b0, stall3}, 32'd1);
    rst3 = 1;
    tick();
    rst3 = 0;
    last3 = 32'h0;
    chk("rstw_rdata", rdata3, 32'h0);
    chk("rstw_stall", {31'b0, stall3}, 32'd0);
    chk("rstw_rv", {31'b0, rv3}, 32'd0);
    chk("rstw_err", {31'b0, err3}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("rstw_no_rv", {31'b0, rv3}, 32'd0);
      chk("rstw_no_stall", {31'b0, stall3}, 32'd0);
    end
    op3(4'h0, 32'h40, 32'h0);
    chk("rstw_reread", rdata3, 32'h55AA55AA);
    for (int i = 0; i < 8; i++) op3(4'h0, 32'(i * 4), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
